divider32_fp: RTL

Iterative IEEE 754 single-precision divider, the inverse-operation companion to the team's FP multiplier. It computes a_i / b_i with a restoring radix-2 mantissa divider, one quotient bit per cycle. It rounds to nearest-even and reports special-case and range flags on the same start/done handshake and flag set as the multiplier. It sits beside the multiplier in the FP datapath.

---
 rtl/divider32_fp.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/divider32_fp.sv
// divider32_fp: iterative IEEE 754 single-precision divider (a_i / b_i).
// Restoring radix-2 mantissa division, one quotient bit per cycle, rounded
// to nearest-even. Subnormal inputs are flushed to zero and results that
// underflow are flushed to signed zero.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i           request, sampled only while idle
//   a_i, b_i          dividend / divisor, captured on the accepting edge
//   quotient_o        result, held until the next result is produced
//   done_o            one-cycle pulse, result and flags valid
//   busy_o            high in every state except idle
//   nan_o             result is quiet NaN
//   infinit_o         result is +/-infinity (any cause)
//   overflow_o        finite result rounded to exponent >= 255
//   underflow_o       nonzero result flushed to zero
//   div_by_zero_o     finite nonzero / zero
module divider32_fp (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quotient_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        nan_o,
  output logic        infinit_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        div_by_zero_o
);

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORMALIZE, ROUND, DONE} state_t;

  state_t             state;
  logic [31:0]        a_r, b_r;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [23:0]        mb_r;
  logic [24:0]        rem_r;
  logic [25:0]        q_r;
  logic [4:0]         cnt_r;
  logic [23:0]        mant_r;
  logic               guard_r, sticky_r;

  // Operand classification
  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_c;
  logic signed [9:0]  exp_calc;

  always_comb begin
    ea       = a_r[30:23];
    eb       = b_r[30:23];
    fa       = a_r[22:0];
    fb       = b_r[22:0];
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (ea == '1) && (fa == '0);
    b_inf    = (eb == '1) && (fb == '0);
    a_nan    = (ea == '1) && (fa != '0);
    b_nan    = (eb == '1) && (fb != '0);
    sign_c   = a_r[31] ^ b_r[31];
    exp_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
  end

  // One restoring-division step
  logic               rem_ge;
  logic [24:0]        rem_sub;
  logic [24:0]        rem_next;

  always_comb begin
    rem_ge   = (rem_r >= {1'b0, mb_r});
    rem_sub  = rem_ge ? (rem_r - {1'b0, mb_r}) : rem_r;
    // rem_sub < mb < 2^24, so bit 24 is always zero before the shift
    rem_next = {rem_sub[23:0], 1'b0};
  end

  // Round-to-nearest-even and final exponent
  logic               rnd_inc;
  logic [24:0]        mant_inc;
  logic [23:0]        mant_fin;
  logic signed [9:0]  exp_fin;

  always_comb begin
    rnd_inc  = guard_r & (sticky_r | mant_r[0]);
    mant_inc = {1'b0, mant_r} + {24'd0, rnd_inc};
    mant_fin = mant_inc[24] ? 24'h800000 : mant_inc[23:0];
    exp_fin  = exp_r + (mant_inc[24] ? 10'sd1 : 10'sd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_r           <= '0;
      b_r           <= '0;
      sign_r        <= 1'b0;
      exp_r         <= '0;
      mb_r          <= '0;
      rem_r         <= '0;
      q_r           <= '0;
      cnt_r         <= '0;
      mant_r        <= '0;
      guard_r       <= 1'b0;
      sticky_r      <= 1'b0;
      quotient_o    <= '0;
      done_o        <= 1'b0;
      busy_o        <= 1'b0;
      nan_o         <= 1'b0;
      infinit_o     <= 1'b0;
      overflow_o    <= 1'b0;
      underflow_o   <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_r           <= a_i;
            b_r           <= b_i;
            nan_o         <= 1'b0;
            infinit_o     <= 1'b0;
            overflow_o    <= 1'b0;
            underflow_o   <= 1'b0;
            div_by_zero_o <= 1'b0;
            busy_o        <= 1'b1;
            state         <= UNPACK;
          end
        end

        UNPACK: begin
          sign_r <= sign_c;
          exp_r  <= exp_calc;
          rem_r  <= {2'b01, fa};
          mb_r   <= {1'b1, fb};
          q_r    <= '0;
          cnt_r  <= 5'd25;
          // Special cases in priority order; the else-chain encodes it
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            quotient_o <= 32'h7FC00000;
            nan_o      <= 1'b1;
            done_o     <= 1'b1;
            state      <= DONE;
          end else if (b_zero && !a_inf) begin
            quotient_o    <= {sign_c, 31'h7F800000};
            div_by_zero_o <= 1'b1;
            infinit_o     <= 1'b1;
            done_o        <= 1'b1;
            state         <= DONE;
          end else if (a_inf) begin
            quotient_o <= {sign_c, 31'h7F800000};
            infinit_o  <= 1'b1;
            done_o     <= 1'b1;
            state      <= DONE;
          end else if (a_zero || b_inf) begin
            quotient_o <= {sign_c, 31'h00000000};
            done_o     <= 1'b1;
            state      <= DONE;
          end else begin
            state <= DIVIDE;
          end
        end

        DIVIDE: begin
          q_r   <= {q_r[24:0], rem_ge};
          rem_r <= rem_next;
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == '0) state <= NORMALIZE;
        end

        NORMALIZE: begin
          if (q_r[25]) begin
            mant_r   <= q_r[25:2];
            guard_r  <= q_r[1];
            sticky_r <= q_r[0] | (|rem_r);
          end else begin
            mant_r   <= q_r[24:1];
            guard_r  <= q_r[0];
            sticky_r <= |rem_r;
            exp_r    <= exp_r - 10'sd1;
          end
          state <= ROUND;
        end

        ROUND: begin
          if (exp_fin >= 10'sd255) begin
            quotient_o <= {sign_r, 31'h7F800000};
            overflow_o <= 1'b1;
            infinit_o  <= 1'b1;
          end else if (exp_fin <= 10'sd0) begin
            quotient_o  <= {sign_r, 31'h00000000};
            underflow_o <= 1'b1;
          end else begin
            quotient_o <= {sign_r, exp_fin[7:0], mant_fin[22:0]};
          end
          done_o <= 1'b1;
          state  <= DONE;
        end

        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
